// File: rtl/i281_instr_fetch.sv
// i281 fetch stage: program counter, two-bank code word select, instruction register
// with valid/ready handshake, branch redirect/flush and a saturating fetch counter.
// Optional breakpoint logic is enabled by defining I281_FETCH_BP_EN.
module i281_instr_fetch #(
    parameter int PC_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic [255:0]     code_low,
    input  logic [255:0]     code_high,
    output logic [15:0]      ir,
    output logic [PC_W-1:0]  ir_pc,
    output logic             ir_valid,
    input  logic             ir_ready,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [7:0]       br_offset,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] fetch_cnt
`ifdef I281_FETCH_BP_EN
    ,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_arm,
    output logic             bp_hit
`endif
);

    logic [15:0]      code_mem [0:31];
    logic [15:0]      fetch_word;
    logic [PC_W-1:0]  br_target;
    logic             bp_block;
    logic             load;

    logic [15:0]      ir_reg,        ir_next;
    logic [PC_W-1:0]  ir_pc_reg,     ir_pc_next;
    logic             ir_valid_reg,  ir_valid_next;
    logic [PC_W-1:0]  pc_reg,        pc_next;
    logic [CNT_W-1:0] fetch_cnt_reg, fetch_cnt_next;

    // Flatten both banks into one 32-word view so pc[4] selects the bank.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bank
            assign code_mem[gi]      = code_low[16*gi +: 16];
            assign code_mem[gi + 16] = code_high[16*gi +: 16];
        end
    endgenerate

    assign fetch_word = code_mem[pc_reg];

    // Target is formed in 9 bits then truncated, giving mod-32 wrap.
    assign br_target = PC_W'(9'(br_pc) + 9'd1 + {br_offset[7], br_offset});

`ifdef I281_FETCH_BP_EN
    logic bp_hit_reg, bp_hit_next;

    // Once hit, stay blocked for as long as the breakpoint remains armed.
    assign bp_block = bp_arm & (bp_hit_reg | (pc_reg == bp_addr));

    always_comb begin
        bp_hit_next = bp_hit_reg;
        if (!bp_arm)
            bp_hit_next = 1'b0;
        else if (run_en && !br_taken && (!ir_valid_reg || ir_ready) && pc_reg == bp_addr)
            bp_hit_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bp_hit_reg <= 1'b0;
        else
            bp_hit_reg <= bp_hit_next;
    end

    assign bp_hit = bp_hit_reg;
`else
    assign bp_block = 1'b0;
`endif

    assign load = run_en & ~br_taken & (~ir_valid_reg | ir_ready) & ~bp_block;

    always_comb begin
        ir_next        = ir_reg;
        ir_pc_next     = ir_pc_reg;
        ir_valid_next  = ir_valid_reg;
        pc_next        = pc_reg;
        fetch_cnt_next = fetch_cnt_reg;
        if (br_taken) begin
            pc_next       = br_target;
            ir_valid_next = 1'b0;
        end else if (load) begin
            ir_next       = fetch_word;
            ir_pc_next    = pc_reg;
            ir_valid_next = 1'b1;
            pc_next       = pc_reg + PC_W'(1);
            if (fetch_cnt_reg != {CNT_W{1'b1}})
                fetch_cnt_next = fetch_cnt_reg + CNT_W'(1);
        end else if (ir_valid_reg && ir_ready) begin
            // Decode took the word but nothing replaces it.
            ir_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg        <= 16'h0000;
            ir_pc_reg     <= '0;
            ir_valid_reg  <= 1'b0;
            pc_reg        <= '0;
            fetch_cnt_reg <= '0;
        end else begin
            ir_reg        <= ir_next;
            ir_pc_reg     <= ir_pc_next;
            ir_valid_reg  <= ir_valid_next;
            pc_reg        <= pc_next;
            fetch_cnt_reg <= fetch_cnt_next;
        end
    end

    assign ir        = ir_reg;
    assign ir_pc     = ir_pc_reg;
    assign ir_valid  = ir_valid_reg;
    assign pc        = pc_reg;
    assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_i281_instr_fetch.sv
// Directed bench for i281_instr_fetch: reset, streaming, bank/wrap, stall, branch,
// counter saturation and (with I281_FETCH_BP_EN) breakpoint behaviour.
module tb_i281_instr_fetch;

    localparam int PC_W  = 5;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run_en;
    logic [255:0]     code_low;
    logic [255:0]     code_high;
    logic [15:0]      ir;
    logic [PC_W-1:0]  ir_pc;
    logic             ir_valid;
    logic             ir_ready;
    logic             br_taken;
    logic [PC_W-1:0]  br_pc;
    logic [7:0]       br_offset;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] fetch_cnt;
`ifdef I281_FETCH_BP_EN
    logic [PC_W-1:0]  bp_addr;
    logic             bp_arm;
    logic             bp_hit;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    i281_instr_fetch #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_en    (run_en),
        .code_low  (code_low),
        .code_high (code_high),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .br_taken  (br_taken),
        .br_pc     (br_pc),
        .br_offset (br_offset),
        .pc        (pc),
        .fetch_cnt (fetch_cnt)
`ifdef I281_FETCH_BP_EN
        ,
        .bp_addr   (bp_addr),
        .bp_arm    (bp_arm),
        .bp_hit    (bp_hit)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-14s got=%0h", tag, got);
        end else begin
            $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected code image: low[0]=3000, low[1]=8308, low[k]=1000+k, high[k]=2000+k.
    function automatic logic [15:0] word_at(input int a);
        if (a == 0)      return 16'h3000;
        else if (a == 1) return 16'h8308;
        else if (a < 16) return 16'h1000 + 16'(a);
        else             return 16'h2000 + 16'(a - 16);
    endfunction

    initial begin
        for (int k = 0; k < 16; k++) begin
            code_low[16*k +: 16]  = word_at(k);
            code_high[16*k +: 16] = word_at(16 + k);
        end
        rst_n = 1'b0; run_en = 1'b0; ir_ready = 1'b0;
        br_taken = 1'b0; br_pc = '0; br_offset = '0;
`ifdef I281_FETCH_BP_EN
        bp_addr = '0; bp_arm = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_pc",    32'(pc), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_ir",    32'(ir), 32'd0);
        check("rst_cnt",   32'(fetch_cnt), 32'd0);

        // Streaming: two first words, then around both banks and past the wrap.
        rst_n = 1'b1; run_en = 1'b1; ir_ready = 1'b1;
        @(negedge clk);
        check("s0_ir",    32'(ir), 32'h3000);
        check("s0_pc",    32'(ir_pc), 32'd0);
        check("s0_valid", 32'(ir_valid), 32'd1);
        @(negedge clk);
        check("s1_ir",  32'(ir), 32'h8308);
        check("s1_pc",  32'(ir_pc), 32'd1);
        check("s1_cnt", 32'(fetch_cnt), 32'd2);
        for (int i = 2; i < 34; i++) begin
            @(negedge clk);
            check($sformatf("wrap%0d_pc", i), 32'(ir_pc), 32'(i % 32));
            check($sformatf("wrap%0d_ir", i), 32'(ir), 32'(word_at(i % 32)));
        end
        check("wrap_cnt", 32'(fetch_cnt), 32'd34);
        check("wrap_nxt", 32'(pc), 32'd2);

        // Stall three cycles with a valid word held.
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ir",  32'(ir), 32'h8308);
            check("stall_pc",  32'(pc), 32'd2);
            check("stall_cnt", 32'(fetch_cnt), 32'd34);
            check("stall_vld", 32'(ir_valid), 32'd1);
        end

        // Accept with run_en low: word drained, pc frozen.
        run_en = 1'b0; ir_ready = 1'b1;
        @(negedge clk);
        check("drain_vld", 32'(ir_valid), 32'd0);
        check("drain_pc",  32'(pc), 32'd2);
        @(negedge clk);
        check("idle_pc",   32'(pc), 32'd2);

        // Branch forward: 4+1+14 = 19.
        run_en = 1'b1; br_taken = 1'b1; br_pc = 5'd4; br_offset = 8'h0E;
        @(negedge clk);
        check("br1_pc",  32'(pc), 32'd19);
        check("br1_vld", 32'(ir_valid), 32'd0);
        check("br1_cnt", 32'(fetch_cnt), 32'd34);
        br_taken = 1'b0;
        @(negedge clk);
        check("br1_irpc", 32'(ir_pc), 32'd19);
        check("br1_ir",   32'(ir), 32'h2003);
        check("br1_cnt2", 32'(fetch_cnt), 32'd35);

        // Branch backward during a stall: 2+1-8 = -5 -> 27.
        ir_ready = 1'b0; br_taken = 1'b1; br_pc = 5'd2; br_offset = 8'hF8;
        @(negedge clk);
        check("br2_pc",  32'(pc), 32'd27);
        check("br2_vld", 32'(ir_valid), 32'd0);
        br_taken = 1'b0; ir_ready = 1'b1;
        @(negedge clk);
        check("br2_irpc", 32'(ir_pc), 32'd27);
        check("br2_ir",   32'(ir), 32'h200B);

        // Branch target wrap: 31+1+0 -> 0, with run_en low.
        run_en = 1'b0; br_taken = 1'b1; br_pc = 5'd31; br_offset = 8'h00;
        @(negedge clk);
        check("br3_pc", 32'(pc), 32'd0);
        br_taken = 1'b0;

        // Asynchronous reset between edges, with a branch asserted meanwhile.
        run_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc",  32'(pc), 32'd0);
        check("arst_vld", 32'(ir_valid), 32'd0);
        check("arst_ir",  32'(ir), 32'd0);
        check("arst_cnt", 32'(fetch_cnt), 32'd0);
        br_taken = 1'b1; br_pc = 5'd10; br_offset = 8'h05;
        @(negedge clk);
        check("rstbr_pc", 32'(pc), 32'd0);
        br_taken = 1'b0;

        // Counter saturation at 2**CNT_W-1 = 63.
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        check("sat_cnt", 32'(fetch_cnt), 32'd63);
        check("sat_irpc", 32'(ir_pc), 32'(69 % 32));

`ifdef I281_FETCH_BP_EN
        rst_n = 1'b0;
        @(negedge clk);
        bp_arm = 1'b1; bp_addr = 5'd5; rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("bp_irpc", 32'(ir_pc), 32'd4);
        check("bp_hit",  32'(bp_hit), 32'd1);
        check("bp_pc",   32'(pc), 32'd5);
        bp_arm = 1'b0;
        @(negedge clk);
        check("bp_clr",   32'(bp_hit), 32'd0);
        check("bp_irpc2", 32'(ir_pc), 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
